// File: rtl/corr_regs_pkg.sv
// Register map of the DDS/PRN correlator channel plus the sweep sequencer's
// state encoding and bus-operation type.
package corr_regs_pkg;

  localparam logic [31:0] GLOBAL_RUN = 32'hFE00_0100;
  localparam logic [31:0] FREQ_ADD   = 32'hFE00_0300;
  localparam logic [31:0] FREQ_PH    = 32'hFE00_0304;
  localparam logic [31:0] FREQ_CTL   = 32'hFE00_030C;
  localparam logic [31:0] CHIP_FREQ  = 32'hFE00_0500;
  localparam logic [31:0] CHIP_PH    = 32'hFE00_0504;
  localparam logic [31:0] PRN        = 32'hFE00_050C;
  localparam logic [31:0] CORR_CNT   = 32'hFE00_0700;
  localparam logic [31:0] CORR_LO    = 32'hFE00_0704;
  localparam logic [31:0] CORR_HI    = 32'hFE00_0708;
  localparam logic [31:0] CORR_STAT  = 32'hFE00_070C;

  // Bus-op ROM indices: 0..8 channel configuration, 9..10 park sequence.
  localparam logic [3:0] STEP_CFG_LAST = 4'd8;
  localparam logic [3:0] STEP_PARK0    = 4'd9;
  localparam logic [3:0] STEP_PARK1    = 4'd10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CFG,
    S_POLL,
    S_RD_LO,
    S_RD_HI,
    S_RD_CNT,
    S_NEXT,
    S_PARK
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } bus_op_t;

endpackage

// File: rtl/corr_mag_acc.sv
// Magnitude of a signed 64-bit correlation dump, accumulated with saturation
// at all-ones; clr_i has priority over add_i.
module corr_mag_acc (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        add_i,
  input  logic [63:0] corr_i,
  output logic [63:0] acc_o
);

  logic [63:0] acc_q;
  logic [63:0] mag;
  logic [64:0] sum;

  // NOTE: mag gets a default first so no path through this block leaves it unassigned (no latch).
  always_comb begin
    mag = corr_i;
    if (corr_i[63]) begin
      // The most negative value has no positive twin; clamp to the largest positive.
      mag = (corr_i == 64'h8000_0000_0000_0000) ? 64'h7FFF_FFFF_FFFF_FFFF
                                                : (~corr_i + 64'd1);
    end
  end

  assign sum = {1'b0, acc_q} + {1'b0, mag};

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      acc_q <= '0;
    end else if (add_i) begin
      acc_q <= sum[64] ? '1 : sum[63:0];
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/correlator_sweep_ctrl.sv
// Bus-master sweep sequencer: programs the correlator per frequency bin, polls
// and reads EPOCHS dumps, sums |corr| and keeps the strongest bin.
module correlator_sweep_ctrl
  import corr_regs_pkg::*;
#(
  parameter int unsigned EPOCHS   = 4,
  parameter int unsigned POLL_GAP = 16,
  parameter int unsigned TIMEOUT  = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] freq_base,
  input  logic [31:0] freq_step,
  input  logic [31:0] chip_freq,
  input  logic [31:0] prn_init,
  input  logic [7:0]  num_bins,
  output logic [31:0] addr,
  output logic [31:0] Wdata,
  output logic        write,
  output logic        read,
  input  logic [31:0] Rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  best_bin,
  output logic [63:0] best_mag
);

  state_e      state_q;
  logic [3:0]  step_q;
  logic [7:0]  bin_q, nb_q, epoch_q, best_bin_q;
  logic [31:0] gap_q, tcnt_q, freq_q, addr_q, wdata_q;
  logic [63:0] corr_q, acc, best_mag_q;
  logic        write_q, read_q, busy_q, done_q, err_q, quiet_q;
  logic        timeout_hit, acc_add, acc_clr;

  function automatic bus_op_t rom_op(input logic [3:0] idx, input logic [31:0] fw,
                                     input logic [31:0] cf, input logic [31:0] prn);
    bus_op_t op;
    case (idx)
      4'd0:    op = '{GLOBAL_RUN, 32'd0};
      4'd1:    op = '{FREQ_CTL,   32'd0};
      4'd2:    op = '{FREQ_ADD,   fw};
      4'd3:    op = '{FREQ_PH,    32'd0};
      4'd4:    op = '{CHIP_FREQ,  cf};
      4'd5:    op = '{CHIP_PH,    32'd0};
      4'd6:    op = '{PRN,        prn};
      4'd7:    op = '{FREQ_CTL,   32'd1};
      4'd8:    op = '{GLOBAL_RUN, 32'd1};
      4'd9:    op = '{GLOBAL_RUN, 32'd0};
      4'd10:   op = '{FREQ_CTL,   32'd0};
      default: op = '{32'd0,      32'd0};
    endcase
    return op;
  endfunction

  assign timeout_hit = (state_q == S_POLL) && (tcnt_q == 32'(TIMEOUT - 1));
  assign acc_add     = (state_q == S_RD_CNT) && !abort;
  assign acc_clr     = (state_q == S_IDLE) || (state_q == S_NEXT);

  corr_mag_acc u_mag_acc (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (acc_clr),
    .add_i  (acc_add),
    .corr_i (corr_q),
    .acc_o  (acc)
  );

  // NOTE: non-blocking assignments only, so every decision below sees pre-edge register values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;   step_q <= '0;     bin_q <= '0;      nb_q <= '0;
      epoch_q <= '0;       gap_q <= '0;      tcnt_q <= '0;     freq_q <= '0;
      corr_q <= '0;        quiet_q <= 1'b0;  addr_q <= '0;     wdata_q <= '0;
      write_q <= 1'b0;     read_q <= 1'b0;   busy_q <= 1'b0;   done_q <= 1'b0;
      err_q <= 1'b0;       best_bin_q <= '0; best_mag_q <= '0;
    end else begin
      write_q <= 1'b0;
      read_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      if (state_q != S_IDLE && state_q != S_PARK && (abort || timeout_hit)) begin
        // Any pending read result is simply dropped; the channel is parked.
        state_q          <= S_PARK;
        step_q           <= STEP_PARK1;
        write_q          <= 1'b1;
        {addr_q, wdata_q} <= rom_op(STEP_PARK0, freq_q, chip_freq, prn_init);
        if (abort) quiet_q <= 1'b1;
        else       err_q   <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: if (start && !abort) begin
            err_q      <= 1'b0;
            quiet_q    <= 1'b0;
            best_bin_q <= '0;
            best_mag_q <= '0;
            bin_q      <= '0;
            epoch_q    <= '0;
            nb_q       <= num_bins;
            freq_q     <= freq_base;
            if (num_bins == 8'd0) begin
              done_q <= 1'b1;
            end else begin
              state_q           <= S_CFG;
              busy_q            <= 1'b1;
              step_q            <= 4'd1;
              write_q           <= 1'b1;
              {addr_q, wdata_q} <= rom_op(4'd0, freq_base, chip_freq, prn_init);
            end
          end
          S_CFG: begin
            write_q           <= 1'b1;
            {addr_q, wdata_q} <= rom_op(step_q, freq_q, chip_freq, prn_init);
            if (step_q == STEP_CFG_LAST) begin
              state_q <= S_POLL;
              gap_q   <= '0;
              tcnt_q  <= '0;
            end else begin
              step_q <= step_q + 4'd1;
            end
          end
          S_POLL: begin
            tcnt_q <= tcnt_q + 32'd1;
            if (read_q) begin
              if (Rdata[0]) begin
                state_q <= S_RD_LO;
                read_q  <= 1'b1;
                addr_q  <= CORR_LO;
              end else begin
                gap_q <= 32'd1;
              end
            end else if (gap_q >= POLL_GAP) begin
              read_q <= 1'b1;
              addr_q <= CORR_STAT;
              gap_q  <= '0;
            end else begin
              gap_q <= gap_q + 32'd1;
            end
          end
          S_RD_LO: begin
            corr_q[31:0] <= Rdata;
            state_q      <= S_RD_HI;
            read_q       <= 1'b1;
            addr_q       <= CORR_HI;
          end
          S_RD_HI: begin
            corr_q[63:32] <= Rdata;
            state_q       <= S_RD_CNT;
            read_q        <= 1'b1;
            addr_q        <= CORR_CNT;
          end
          S_RD_CNT: begin
            // The dump count is read to complete the channel's dump handshake; the sweep needs only the sum.
            epoch_q <= epoch_q + 8'd1;
            if ((epoch_q + 8'd1) == 8'(EPOCHS)) begin
              state_q <= S_NEXT;
            end else begin
              state_q <= S_POLL;
              gap_q   <= 32'd1;
              tcnt_q  <= '0;
            end
          end
          S_NEXT: begin
            if (acc > best_mag_q || bin_q == 8'd0) begin
              best_bin_q <= bin_q;
              best_mag_q <= acc;
            end
            epoch_q <= '0;
            bin_q   <= bin_q + 8'd1;
            freq_q  <= freq_q + freq_step;
            write_q <= 1'b1;
            if ((bin_q + 8'd1) == nb_q) begin
              state_q           <= S_PARK;
              step_q            <= STEP_PARK1;
              {addr_q, wdata_q} <= rom_op(STEP_PARK0, freq_q, chip_freq, prn_init);
            end else begin
              state_q           <= S_CFG;
              step_q            <= 4'd1;
              {addr_q, wdata_q} <= rom_op(4'd0, freq_q, chip_freq, prn_init);
            end
          end
          S_PARK: begin
            if (step_q == STEP_PARK1) begin
              write_q           <= 1'b1;
              {addr_q, wdata_q} <= rom_op(STEP_PARK1, freq_q, chip_freq, prn_init);
              step_q            <= step_q + 4'd1;
            end else begin
              state_q <= S_IDLE;
              step_q  <= '0;
              busy_q  <= 1'b0;
              done_q  <= !(quiet_q || abort);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign addr     = addr_q;
  assign Wdata    = wdata_q;
  assign write    = write_q;
  assign read     = read_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign best_bin = best_bin_q;
  assign best_mag = best_mag_q;

endmodule

// File: tb/tb_correlator_sweep_ctrl.sv
// Directed bench: a register-port responder plus a sweep-level model that
// predicts every bus write and the reported best bin, checked each cycle.
module tb_correlator_sweep_ctrl;
  import corr_regs_pkg::*;

  localparam int unsigned EP = 2, GAP = 2, TO = 200;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [31:0] freq_base = '0, freq_step = '0;
  logic [31:0] chip_freq = 32'hC0FF_EE01, prn_init = 32'h5A5A_1234;
  logic [7:0]  num_bins = '0;
  logic [31:0] addr, Wdata, Rdata;
  logic        write, read, busy, done, err;
  logic [7:0]  best_bin;
  logic [63:0] best_mag;

  int checks = 0, errors = 0, done_cnt = 0;
  logic [63:0] corr_tbl [0:15];
  int  dump_idx = 0, poll_cnt = 0;
  bit  stat_never = 1'b0;
  bus_op_t     exp_wr[$];
  logic [7:0]  exp_bin = '0;
  logic [63:0] exp_mag = '0;
  logic        exp_err = 1'b0;
  bit          exp_done = 1'b1, no_busy = 1'b0, mon_on = 1'b0;

  // Standalone accumulator for the saturation corner (unreachable with EP=2).
  logic        clr_t = 1'b0, add_t = 1'b0;
  logic [63:0] corr_t = '0, acc_t;

  always #5 clk = ~clk;

  correlator_sweep_ctrl #(.EPOCHS(EP), .POLL_GAP(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .freq_base(freq_base), .freq_step(freq_step), .chip_freq(chip_freq),
    .prn_init(prn_init), .num_bins(num_bins),
    .addr(addr), .Wdata(Wdata), .write(write), .read(read), .Rdata(Rdata),
    .busy(busy), .done(done), .err(err), .best_bin(best_bin), .best_mag(best_mag)
  );

  corr_mag_acc u_acc (.clk(clk), .rst(rst), .clr_i(clr_t), .add_i(add_t),
                      .corr_i(corr_t), .acc_o(acc_t));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Correlator register port: status is set on the 2nd poll of each dump.
  always_comb begin
    Rdata = 32'd0;
    if (read) begin
      case (addr)
        CORR_STAT: Rdata = {31'd0, 1'(!stat_never && poll_cnt == 1)};
        CORR_LO:   Rdata = corr_tbl[dump_idx[3:0]][31:0];
        CORR_HI:   Rdata = corr_tbl[dump_idx[3:0]][63:32];
        CORR_CNT:  Rdata = 32'(dump_idx + 1);
        default:   Rdata = 32'hDEAD_BEEF;
      endcase
    end
  end

  always @(posedge clk) begin
    if (start) begin
      dump_idx <= 0;
      poll_cnt <= 0;
    end else if (read && addr == CORR_STAT) begin
      poll_cnt <= poll_cnt + 1;
    end else if (read && addr == CORR_CNT) begin
      poll_cnt <= 0;
      dump_idx <= dump_idx + 1;
    end
  end

  function automatic logic [63:0] mag_of(input logic [63:0] v);
    if (v == 64'h8000_0000_0000_0000) return 64'h7FFF_FFFF_FFFF_FFFF;
    if (v[63]) return -v;
    return v;
  endfunction

  // Sweep model: every bin gets the 9-write config, dumps are summed, the
  // first strictly larger sum wins; cut stops after bin 0's config (timeout/abort).
  task automatic build_expect(input int nb, input logic [31:0] base,
                              input logic [31:0] step, input bit cut);
    logic [64:0] s;
    logic [63:0] sum;
    logic [31:0] fw;
    exp_wr.delete();
    exp_bin = '0;
    exp_mag = '0;
    for (int b = 0; b < nb; b++) begin
      fw = base + 32'(b) * step;
      exp_wr.push_back('{GLOBAL_RUN, 32'd0});
      exp_wr.push_back('{FREQ_CTL, 32'd0});
      exp_wr.push_back('{FREQ_ADD, fw});
      exp_wr.push_back('{FREQ_PH, 32'd0});
      exp_wr.push_back('{CHIP_FREQ, chip_freq});
      exp_wr.push_back('{CHIP_PH, 32'd0});
      exp_wr.push_back('{PRN, prn_init});
      exp_wr.push_back('{FREQ_CTL, 32'd1});
      exp_wr.push_back('{GLOBAL_RUN, 32'd1});
      if (cut) break;
      sum = '0;
      for (int d = 0; d < int'(EP); d++) begin
        s   = {1'b0, sum} + {1'b0, mag_of(corr_tbl[b * int'(EP) + d])};
        sum = s[64] ? '1 : s[63:0];
      end
      if (b == 0 || sum > exp_mag) begin
        exp_bin = 8'(b);
        exp_mag = sum;
      end
    end
    if (nb > 0) begin
      exp_wr.push_back('{GLOBAL_RUN, 32'd0});
      exp_wr.push_back('{FREQ_CTL, 32'd0});
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    bus_op_t op;
    if (mon_on) begin
      check("rw_excl", 64'(write & read), 64'd0);
      if (!write) check("wdata_idle", 64'(Wdata), 64'd0);
      if (!write && !read) check("addr_idle", 64'(addr), 64'd0);
      if (no_busy) check("busy_low", 64'(busy), 64'd0);
      if (write) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wr: got addr %h data %h want no write", addr, Wdata);
        end else begin
          op = exp_wr.pop_front();
          check("wr_addr", 64'(addr), 64'(op.addr));
          check("wr_data", 64'(Wdata), 64'(op.data));
        end
      end
      if (done) begin
        done_cnt++;
        if (!exp_done) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: got done=1 want done=0");
        end else begin
          check("done_best_bin", 64'(best_bin), 64'(exp_bin));
          check("done_best_mag", best_mag, exp_mag);
          check("done_err", 64'(err), 64'(exp_err));
        end
      end
    end
  end

  task automatic pulse_start(input logic [7:0] nb);
    num_bins = nb;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (nb != 8'd0) check("first_wr", {31'd0, write, addr}, {31'd0, 1'b1, GLOBAL_RUN});
  endtask

  task automatic run_sweep(input logic [7:0] nb, input int bound);
    int base;
    int i;
    base = done_cnt;
    pulse_start(nb);
    i = 0;
    while (done_cnt == base && i < bound) begin
      @(posedge clk);
      i++;
    end
    #1;
    check("sweep_done_seen", 64'(done_cnt - base), 64'd1);
    check("wr_left", 64'(exp_wr.size()), 64'd0);
  endtask

  initial begin
    int base;
    bit seen;
    int i;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {addr, Wdata}, 64'd0);
    check("rst_flags", {59'd0, write, read, busy, done, err}, 64'd0);
    check("rst_best", best_mag | 64'(best_bin), 64'd0);
    rst = 1'b0;
    mon_on = 1'b1;

    // num_bins = 0: done one cycle after start, no traffic, never busy.
    build_expect(0, 32'd0, 32'd0, 1'b0);
    no_busy = 1'b1;
    pulse_start(8'd0);
    check("nb0_done", 64'(done), 64'd1);
    @(posedge clk); #1;
    check("nb0_pulse_end", 64'(done), 64'd0);
    repeat (3) @(posedge clk);
    no_busy = 1'b0;

    // One bin, two dumps -5 and +7.
    corr_tbl[0] = -64'sd5;
    corr_tbl[1] = 64'sd7;
    freq_base = 32'h0100_0000;
    build_expect(1, freq_base, 32'd0, 1'b0);
    run_sweep(8'd1, 400);
    check("t3_best_mag", best_mag, 64'd12);
    check("t3_best_bin", 64'(best_bin), 64'd0);

    // Three bins, sums 10/30/30, freq word wraps past 2^32.
    corr_tbl[0] = 64'sd4;   corr_tbl[1] = -64'sd6;
    corr_tbl[2] = -64'sd10; corr_tbl[3] = 64'sd20;
    corr_tbl[4] = 64'sd30;  corr_tbl[5] = 64'sd0;
    freq_base = 32'hFFFF_FF00;
    freq_step = 32'h0000_0100;
    build_expect(3, freq_base, freq_step, 1'b0);
    run_sweep(8'd3, 1000);
    check("t4_best_bin", 64'(best_bin), 64'd1);
    check("t4_best_mag", best_mag, 64'd30);

    // Most negative dump clamps to the largest positive magnitude.
    corr_tbl[0] = 64'h8000_0000_0000_0000;
    corr_tbl[1] = -64'sd1;
    build_expect(1, freq_base, freq_step, 1'b0);
    run_sweep(8'd1, 400);
    check("min_mag", best_mag, 64'h8000_0000_0000_0000);

    // Status never set: timeout sets err, parks, still pulses done.
    stat_never = 1'b1;
    build_expect(2, freq_base, freq_step, 1'b1);
    exp_err = 1'b1;
    run_sweep(8'd2, 1000);
    check("to_err", 64'(err), 64'd1);
    stat_never = 1'b0;
    build_expect(0, 32'd0, 32'd0, 1'b0);
    exp_err = 1'b0;
    pulse_start(8'd0);
    check("err_cleared", 64'(err), 64'd0);
    repeat (2) @(posedge clk);

    // Abort while polling: park writes, no done.
    stat_never = 1'b1;
    build_expect(1, freq_base, freq_step, 1'b1);
    exp_done = 1'b0;
    base = done_cnt;
    pulse_start(8'd1);
    seen = 1'b0;
    i = 0;
    while (!seen && i < 200) begin
      @(negedge clk);
      seen = read && addr == CORR_STAT;
      i++;
    end
    check("abort_poll_seen", 64'(seen), 64'd1);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    i = 0;
    while (busy && i < 50) begin
      @(posedge clk);
      i++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("abort_idle", 64'(busy), 64'd0);
    check("abort_no_done", 64'(done_cnt - base), 64'd0);
    check("abort_wr_left", 64'(exp_wr.size()), 64'd0);
    stat_never = 1'b0;

    // Reset in the middle of configuration: no further bus access.
    build_expect(1, freq_base, freq_step, 1'b1);
    while (exp_wr.size() > 3) void'(exp_wr.pop_back());
    pulse_start(8'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_outs", {addr, Wdata}, 64'd0);
    check("rst_mid_flags", {59'd0, write, read, busy, done, err}, 64'd0);
    check("rst_mid_best", best_mag | 64'(best_bin), 64'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_mid_wr_left", 64'(exp_wr.size()), 64'd0);
    check("rst_mid_no_done", 64'(done_cnt - base), 64'd0);
    exp_done = 1'b1;

    // Saturating accumulate on the magnitude unit itself.
    clr_t = 1'b1;
    @(posedge clk); #1 clr_t = 1'b0;
    corr_t = 64'h8000_0000_0000_0000;
    add_t = 1'b1;
    @(posedge clk); #1;
    check("acc_one", acc_t, 64'h7FFF_FFFF_FFFF_FFFF);
    repeat (2) @(posedge clk);
    #1 add_t = 1'b0;
    check("acc_sat", acc_t, 64'hFFFF_FFFF_FFFF_FFFF);

    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
